fft_r2_stage_pipe: RTL and testbench

- Pipelined, streaming radix-2 DIT butterfly stage with a handshake interface; the registered, parametrised successor to the team's combinational final-stage twiddle+butterfly array.
- Accepts one complex pair (a, b) per cycle and multiplies b by a twiddle from an internal loadable table, indexed by pair position within the frame.
- Emits a+b·w and a−b·w with optional per-stage scaling and saturation.
- Sits between earlier FFT stages (or the input buffer) and the output reorder buffer.

---
 rtl/fft_r2_stage_pipe.sv | 163 ++++++++++++++++
 tb/tb_fft_r2_stage_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_stage_pipe.sv
// Streaming radix-2 DIT butterfly stage: S1 capture + twiddle read, S2 complex multiply,
// S3 butterfly/scale/saturate. Define FFT_STAGE_SAT_CNT_EN to add the sat_cnt output.
module fft_r2_stage_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int TW_W  = 10,
    parameter int NPAIR = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   a_r,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [IN_W-1:0]   b_r,
    input  logic signed [IN_W-1:0]   b_i,
    input  logic                     scale,
    input  logic                     tw_we,
    input  logic [$clog2(NPAIR)-1:0] tw_addr,
    input  logic signed [TW_W-1:0]   tw_r,
    input  logic signed [TW_W-1:0]   tw_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  p_r,
    output logic signed [OUT_W-1:0]  p_i,
    output logic signed [OUT_W-1:0]  n_r,
    output logic signed [OUT_W-1:0]  n_i,
    output logic [$clog2(NPAIR)-1:0] out_idx,
`ifdef FFT_STAGE_SAT_CNT_EN
    output logic [15:0]              sat_cnt,
`endif
    output logic                     out_last
);
    localparam int AW     = $clog2(NPAIR);
    localparam int STAGES = 3;
    localparam int SH     = TW_W - 2;
    // Two guard bits keep the full product difference plus rounding term exact.
    localparam int PW     = IN_W + TW_W + 2;
    localparam int BW     = (IN_W + 2 > OUT_W) ? IN_W + 2 : OUT_W;
    localparam logic signed [PW-1:0]   RND   = PW'(2 ** (SH - 1));
    localparam logic signed [BW-1:0]   ONE   = BW'(1);
    localparam logic signed [TW_W-1:0] UNITY = TW_W'(2 ** SH);

    function automatic logic ovf_in(input logic signed [PW-1:0] v);
        return !(&v[PW-1:IN_W-1] || ~|v[PW-1:IN_W-1]);
    endfunction

    function automatic logic signed [IN_W-1:0] sat_in(input logic signed [PW-1:0] v);
        if (ovf_in(v))
            return v[PW-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        return v[IN_W-1:0];
    endfunction

    function automatic logic ovf_out(input logic signed [BW-1:0] v);
        return !(&v[BW-1:OUT_W-1] || ~|v[BW-1:OUT_W-1]);
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [BW-1:0] v);
        if (ovf_out(v))
            return v[BW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [BW-1:0] bfly(input logic signed [IN_W-1:0] a,
                                                   input logic signed [IN_W-1:0] x,
                                                   input logic sub, input logic sc);
        logic signed [BW-1:0] v;
        v = sub ? BW'(a) - BW'(x) : BW'(a) + BW'(x);
        if (sc) v = (v + ONE) >>> 1;
        return v;
    endfunction

    logic                   adv, acc;
    logic [STAGES:1]        vld_pipe;
    logic [AW-1:0]          cnt, idx1, idx2;
    logic signed [TW_W-1:0] twr_mem [NPAIR];
    logic signed [TW_W-1:0] twi_mem [NPAIR];
    logic signed [IN_W-1:0] a1_r, a1_i, b1_r, b1_i, a2_r, a2_i, x2_r, x2_i;
    logic signed [TW_W-1:0] w1_r, w1_i;
    logic                   sc1, sc2;
    logic signed [PW-1:0]   mr, mi;
    logic signed [BW-1:0]   s_r, s_i, d_r, d_i;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign out_valid = vld_pipe[STAGES];

    // Table write ignores the handshake; S1 reads the pre-write value on a same-cycle hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPAIR; k++) begin
                twr_mem[k] <= UNITY;
                twi_mem[k] <= '0;
            end
        end else if (tw_we) begin
            twr_mem[tw_addr] <= tw_r;
            twi_mem[tw_addr] <= tw_i;
        end
    end

    always_comb begin
        mr  = (PW'(b1_r) * PW'(w1_r) - PW'(b1_i) * PW'(w1_i) + RND) >>> SH;
        mi  = (PW'(b1_r) * PW'(w1_i) + PW'(b1_i) * PW'(w1_r) + RND) >>> SH;
        s_r = bfly(a2_r, x2_r, 1'b0, sc2);
        s_i = bfly(a2_i, x2_i, 1'b0, sc2);
        d_r = bfly(a2_r, x2_r, 1'b1, sc2);
        d_i = bfly(a2_i, x2_i, 1'b1, sc2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            cnt      <= '0;
            p_r      <= '0;
            p_i      <= '0;
            n_r      <= '0;
            n_i      <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], acc};
            if (acc) cnt <= cnt + AW'(1);
            a1_r     <= a_r;
            a1_i     <= a_i;
            b1_r     <= b_r;
            b1_i     <= b_i;
            w1_r     <= twr_mem[cnt];
            w1_i     <= twi_mem[cnt];
            sc1      <= scale;
            idx1     <= cnt;
            a2_r     <= a1_r;
            a2_i     <= a1_i;
            x2_r     <= sat_in(mr);
            x2_i     <= sat_in(mi);
            sc2      <= sc1;
            idx2     <= idx1;
            p_r      <= sat_out(s_r);
            p_i      <= sat_out(s_i);
            n_r      <= sat_out(d_r);
            n_i      <= sat_out(d_i);
            out_idx  <= idx2;
            out_last <= (idx2 == AW'(NPAIR - 1));
        end
    end

`ifdef FFT_STAGE_SAT_CNT_EN
    logic msat2, bsat;
    assign bsat = ovf_out(s_r) || ovf_out(s_i) || ovf_out(d_r) || ovf_out(d_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            msat2   <= 1'b0;
            sat_cnt <= '0;
        end else if (adv) begin
            msat2 <= ovf_in(mr) || ovf_in(mi);
            if (vld_pipe[STAGES-1] && (msat2 || bsat) && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_r2_stage_pipe.sv
// Bench for fft_r2_stage_pipe: queue-based arithmetic model checked on every output cycle,
// plus directed vectors with hand-computed results.
module tb_fft_r2_stage_pipe;
    localparam int IN_W  = 8;
    localparam int OUT_W = 8;
    localparam int TW_W  = 10;
    localparam int NPAIR = 16;
    localparam int AW    = $clog2(NPAIR);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b1, scale = 1'b0, tw_we = 1'b0;
    logic signed [IN_W-1:0]  a_r = '0, a_i = '0, b_r = '0, b_i = '0;
    logic [AW-1:0]           tw_addr = '0;
    logic signed [TW_W-1:0]  tw_r = '0, tw_i = '0;
    logic                    in_ready, out_valid, out_last;
    logic signed [OUT_W-1:0] p_r, p_i, n_r, n_i;
    logic [AW-1:0]           out_idx;
`ifdef FFT_STAGE_SAT_CNT_EN
    logic [15:0]             sat_cnt;
`endif

    fft_r2_stage_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TW_W(TW_W), .NPAIR(NPAIR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .scale(scale),
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_r(tw_r), .tw_i(tw_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_r(p_r), .p_i(p_i), .n_r(n_r), .n_i(n_i), .out_idx(out_idx),
`ifdef FFT_STAGE_SAT_CNT_EN
        .sat_cnt(sat_cnt),
`endif
        .out_last(out_last));

    always #5 clk = ~clk;

    typedef struct { int pr; int pi; int nr; int ni; int idx; int last; int sat; } exp_t;

    exp_t q[$];
    exp_t e;
    int   mtw_r[NPAIR], mtw_i[NPAIR];
    int   mcnt = 0, msat = 0, n_last = 0;
    int   n_chk = 0, n_fail = 0;
    int   lat, acc, cyc, j, nv;

    task automatic chk(string nm, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int clamp(int v, int w);
        int lo = -(1 << (w - 1));
        int hi = (1 << (w - 1)) - 1;
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int bf_raw(int a, int x, int sub, int sc);
        int t = sub ? a - x : a + x;
        if (sc != 0) t = (t + 1) >>> 1;
        return t;
    endfunction

    function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi,
                                   int sc, int idx);
        exp_t r;
        int xr_f, xi_f, xr, xi, raw[4];
        xr_f = (br * wr - bi * wi + (1 << (TW_W - 3))) >>> (TW_W - 2);
        xi_f = (br * wi + bi * wr + (1 << (TW_W - 3))) >>> (TW_W - 2);
        xr = clamp(xr_f, IN_W);
        xi = clamp(xi_f, IN_W);
        raw[0] = bf_raw(ar, xr, 0, sc);
        raw[1] = bf_raw(ai, xi, 0, sc);
        raw[2] = bf_raw(ar, xr, 1, sc);
        raw[3] = bf_raw(ai, xi, 1, sc);
        r.pr = clamp(raw[0], OUT_W);
        r.pi = clamp(raw[1], OUT_W);
        r.nr = clamp(raw[2], OUT_W);
        r.ni = clamp(raw[3], OUT_W);
        r.idx  = idx;
        r.last = (idx == NPAIR - 1);
        r.sat  = (xr != xr_f) || (xi != xi_f) || (r.pr != raw[0]) || (r.pi != raw[1]) ||
                 (r.nr != raw[2]) || (r.ni != raw[3]);
        return r;
    endfunction

    // Model update and output comparison; an output held under backpressure is compared
    // against the same queue head every cycle, so it must stay stable.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
            msat = 0;
            for (int k = 0; k < NPAIR; k++) begin
                mtw_r[k] = 1 << (TW_W - 2);
                mtw_i[k] = 0;
            end
        end else begin
            chk("in_ready", in_ready, (!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    e = q[0];
                    chk("p_r", p_r, e.pr);
                    chk("p_i", p_i, e.pi);
                    chk("n_r", n_r, e.nr);
                    chk("n_i", n_i, e.ni);
                    chk("out_idx", out_idx, e.idx);
                    chk("out_last", out_last, e.last);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (e.sat != 0) msat++;
                        if (out_last) n_last++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a_r, a_i, b_r, b_i, mtw_r[mcnt], mtw_i[mcnt], scale, mcnt));
                mcnt = (mcnt + 1) % NPAIR;
            end
            if (tw_we) begin
                mtw_r[tw_addr] = tw_r;
                mtw_i[tw_addr] = tw_i;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(int ar, int ai, int br, int bi, int sc);
        a_r = IN_W'(ar);
        a_i = IN_W'(ai);
        b_r = IN_W'(br);
        b_i = IN_W'(bi);
        scale = (sc != 0);
    endtask

    task automatic send(int ar, int ai, int br, int bi, int sc);
        int n = 0;
        set_pair(ar, ai, br, bi, sc);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!out_valid && l < 50);
        if (!out_valid) chk("out_timeout", 0, 1);
    endtask

    task automatic expect_pair(string nm, int pr, int pi, int nr, int ni, int idx);
        chk({nm, "_pr"}, p_r, pr);
        chk({nm, "_pi"}, p_i, pi);
        chk({nm, "_nr"}, n_r, nr);
        chk({nm, "_ni"}, n_i, ni);
        chk({nm, "_idx"}, out_idx, idx);
    endtask

    task automatic tw_write(int addr, int r, int i);
        tw_addr = AW'(addr);
        tw_r = TW_W'(r);
        tw_i = TW_W'(i);
        tw_we = 1'b1;
        tick();
        tw_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p_r", p_r, 0);
        chk("rst_n_i", n_i, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        tick();
        rst = 1'b0;

        // Unity and -j twiddles, with latency
        tw_write(0, 256, 0);
        tw_write(1, 0, -256);
        send(10, 0, 4, 0, 0);
        wait_out(lat);
        chk("t1_latency", lat, 3);
        expect_pair("t1", 14, 0, 6, 0, 0);
        tick();
        send(10, 0, 4, 2, 0);
        wait_out(lat);
        expect_pair("t2", 12, -4, 8, 4, 1);
        tick();

        // Saturation, both scale settings, plus negative clamp
`ifdef FFT_STAGE_SAT_CNT_EN
        chk("satcnt_init", sat_cnt, 0);
`endif
        send(127, 0, 127, 0, 0);
        wait_out(lat);
        expect_pair("sat_s0", 127, 0, 0, 0, 2);
`ifdef FFT_STAGE_SAT_CNT_EN
        chk("satcnt_after_s0", sat_cnt, 1);
`endif
        tick();
        send(127, 0, 127, 0, 1);
        wait_out(lat);
        expect_pair("sat_s1", 127, 0, 0, 0, 3);
`ifdef FFT_STAGE_SAT_CNT_EN
        chk("satcnt_after_s1", sat_cnt, 1);
`endif
        tick();
        send(-128, -128, -128, -128, 0);
        wait_out(lat);
        expect_pair("sat_neg", -128, -128, 0, 0, 4);
        tick();

        // Same-cycle write to the entry being read: pair sees the old (unity) value
        tw_addr = AW'(5);
        tw_r = '0;
        tw_i = TW_W'(256);
        tw_we = 1'b1;
        set_pair(0, 0, 8, 0, 0);
        in_valid = 1'b1;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        tw_we = 1'b0;
        wait_out(lat);
        expect_pair("tw_old", 8, 0, -8, 0, 5);
        tick();

        // Backpressure: out_ready low for the first 5 cycles
        acc = 0;
        cyc = 0;
        in_valid = 1'b1;
        while (acc < 6 && cyc < 60) begin
            set_pair(acc * 3, -acc, 5 - acc, acc * 2, acc % 2);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 3) begin
                chk("bp_accepts", acc, 3);
                chk("bp_in_ready_low", in_ready, 0);
            end
            if (cyc == 4) chk("bp_hold_valid", out_valid, 1);
            if (in_ready) acc++;
            tick();
            cyc++;
        end
        chk("bp_all_accepted", acc, 6);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Frame wrap over two frames with varied twiddles and intermittent stalls
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NPAIR; k++)
            tw_write(k, ((k * 73) % 1024) - 512, ((k * 151 + 37) % 1024) - 512);
        j = 0;
        cyc = 0;
        n_last = 0;
        while (j < 2 * NPAIR && cyc < 500) begin
            set_pair(((j * 37) % 256) - 128, ((j * 53 + 11) % 256) - 128,
                     ((j * 91 + 5) % 256) - 128, ((j * 29 + 77) % 256) - 128, (j % 3 == 0));
            in_valid = 1'b1;
            out_ready = (cyc % 5 != 3);
            @(negedge clk);
            if (in_ready) j++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("frame_last_cnt", n_last, 2);

        // Reset mid-frame with two pairs in flight
        tw_write(0, 0, 256);
        for (int k = 0; k < 5; k++) begin
            set_pair(k + 1, k, 3, -k, 0);
            in_valid = 1'b1;
            @(negedge clk);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("rst_no_valid", nv, 0);
        tick();
        send(20, 0, 8, 0, 0);
        wait_out(lat);
        expect_pair("post_rst", 28, 0, 12, 0, 0);
        tick();
        drain();
`ifdef FFT_STAGE_SAT_CNT_EN
        chk("sat_cnt_total", sat_cnt, msat);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
